// File: rtl/dm_pkg.sv
// dm_pkg: shared constants for the sized data memory.
//   - RV32I funct3 size/sign codes used by loads and stores
//   - FSM state encoding of the request/response sequencer
package dm_pkg;
   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dm_state_e;
endpackage

// File: rtl/dm_sized_if.sv
// dm_sized_if: request/response channel of the sized data memory.
//   req_valid/req_ready  request handshake
//   req_we               1 = store, 0 = load
//   req_funct3           RV32I size/sign code
//   req_addr             byte address (ADDR_W bits)
//   req_wdata            store data, low bytes used for SB/SH
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            extended load data (0 for stores/errors)
//   rsp_err              misaligned or illegal access
// master = requester (core MEM stage), slave = memory.
interface dm_sized_if #(parameter int ADDR_W = 7);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dm_lane_align.sv
// dm_lane_align: combinational byte-lane steering for RV32I loads/stores.
//   i_we      1 = store, 0 = load
//   i_funct3  size/sign code
//   i_a       byte offset within the word
//   i_wdata   raw store data from the requester
//   i_rword   memory word addressed by the request
//   o_be      per-byte write enable (0 for loads and rejected stores)
//   o_wdata   store data replicated onto the addressed lanes
//   o_rdata   extended load data (0 for stores and rejected loads)
//   o_err     misaligned / illegal access (only when DM_ERR_EN is defined)
// Macro DM_ERR_EN: defined = flag and suppress bad accesses;
// undefined = force-align, illegal loads act as LW, illegal stores drop.
module dm_lane_align
   import dm_pkg::*;
(
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_a,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata,
   output logic        o_err
);
   logic        w_byte, w_half, w_word, w_uns, w_ill;
   logic        w_ok;
   logic [1:0]  w_a;
   logic [15:0] w_sh;

   // decode size; unsigned codes are load-only
   always_comb begin
      w_byte = 1'b0;
      w_half = 1'b0;
      w_word = 1'b0;
      w_uns  = 1'b0;
      w_ill  = 1'b0;
      case (i_funct3)
         F3_B:  w_byte = 1'b1;
         F3_BU: begin w_byte = 1'b1; w_uns = 1'b1; w_ill = i_we; end
         F3_H:  w_half = 1'b1;
         F3_HU: begin w_half = 1'b1; w_uns = 1'b1; w_ill = i_we; end
         F3_W:  w_word = 1'b1;
         default: w_ill = 1'b1;
      endcase
   end

   always_comb begin
      o_be    = '0;
      o_wdata = '0;
      o_rdata = '0;
      o_err   = 1'b0;
      w_a     = i_a;
      w_ok    = ~w_ill;
`ifdef DM_ERR_EN
      if (w_ill || (w_half && i_a[0]) || (w_word && (i_a != 2'b00))) begin
         o_err = 1'b1;
         w_ok  = 1'b0;
      end
`else
      // an illegal load code has no size bit set, so it falls to the word path
      if (w_ill && !i_we) w_ok = 1'b1;
      if (w_half) w_a[0] = 1'b0;
      else if (w_word || w_ill) w_a = 2'b00;
`endif
      w_sh = 16'(i_rword >> {w_a, 3'b000});
      if (w_ok) begin
         if (i_we) begin
            if (w_byte) begin
               o_be    = 4'b0001 << w_a;
               o_wdata = {4{i_wdata[7:0]}};
            end else if (w_half) begin
               o_be    = w_a[1] ? 4'b1100 : 4'b0011;
               o_wdata = {2{i_wdata[15:0]}};
            end else begin
               o_be    = 4'hF;
               o_wdata = i_wdata;
            end
         end else begin
            if (w_byte)      o_rdata = {{24{~w_uns & w_sh[7]}}, w_sh[7:0]};
            else if (w_half) o_rdata = {{16{~w_uns & w_sh[15]}}, w_sh[15:0]};
            else             o_rdata = i_rword;
         end
      end
   end
endmodule

// File: rtl/dm_sized.sv
// dm_sized: byte-addressed data RAM executing RV32I LB/LH/LW/LBU/LHU/SB/SH/SW
// with valid/ready request and response channels and LAT-cycle read latency.
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset (aborts any transaction in flight)
//   bus    dm_sized_if.slave (request and response channels)
// Parameters: ADDR_W byte-address width (depth 2**(ADDR_W-2) words),
//             LAT 1..4 cycles from acceptance to rsp_valid.
// Macro DM_ERR_EN enables misalignment / illegal-funct3 error responses.
module dm_sized
   import dm_pkg::*;
#(
   parameter int ADDR_W = 7,
   parameter int LAT    = 1
) (
   input logic      clk,
   input logic      rst_n,
   dm_sized_if.slave bus
);
   localparam int DEPTH = 2 ** (ADDR_W - 2);

   if (LAT < 1 || LAT > 4) begin : g_lat_chk
      $error("dm_sized: LAT must be in 1..4");
   end

   dm_state_e          r_state, w_nxt;
   logic [2:0]         r_cnt, w_cnt_nxt;
   logic [31:0]        r_rdata;
   logic               r_err;
   logic [31:0]        r_mem [DEPTH];

   logic               w_acc;
   logic [ADDR_W-3:0]  w_widx;
   logic [31:0]        w_rword;
   logic [3:0]         w_be;
   logic [31:0]        w_wd;
   logic [31:0]        w_rd;
   logic               w_err;

   assign w_acc   = bus.req_valid && (r_state == IDLE);
   assign w_widx  = bus.req_addr[ADDR_W-1:2];
   assign w_rword = r_mem[w_widx];

   dm_lane_align u_align (
      .i_we     (bus.req_we),
      .i_funct3 (bus.req_funct3),
      .i_a      (bus.req_addr[1:0]),
      .i_wdata  (bus.req_wdata),
      .i_rword  (w_rword),
      .o_be     (w_be),
      .o_wdata  (w_wd),
      .o_rdata  (w_rd),
      .o_err    (w_err)
   );

   always_comb begin
      w_nxt     = r_state;
      w_cnt_nxt = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_acc) begin
               if (LAT == 1) begin
                  w_nxt = RESP;
               end else begin
                  w_nxt     = WAIT;
                  w_cnt_nxt = 3'(LAT - 1);
               end
            end
         end
         WAIT: begin
            w_cnt_nxt = r_cnt - 3'd1;
            if (r_cnt == 3'd1) w_nxt = RESP;
         end
         RESP: if (bus.rsp_ready) w_nxt = IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_cnt   <= w_cnt_nxt;
         // response is frozen at acceptance, so it holds through backpressure
         if (w_acc) begin
            r_rdata <= w_rd;
            r_err   <= w_err;
         end
      end
   end

   // storage is not reset; stores commit at the acceptance edge
   always_ff @(posedge clk) begin
      if (w_acc && bus.req_we) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_widx][8*i +: 8] <= w_wd[8*i +: 8];
         end
      end
   end

   assign bus.req_ready = (r_state == IDLE);
   assign bus.rsp_valid = (r_state == RESP);
   assign bus.rsp_rdata = r_rdata;
   assign bus.rsp_err   = r_err;
endmodule
